mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter that shares the single unified instruction/data memory of the multicycle MIPS core between the CPU and a debug/monitor port. The debug port is used to read back memory words at a given address and to preload words. The block sits between `top`'s datapath memory interface and the memory array. It serialises accesses through a three-state FSM, with fixed CPU priority and a starvation guard for the debug port.

## Interface

Parameters:
- `AW`, 8: memory word-address width.
- `STARVE_LIMIT`, 4: number of consecutive CPU grants, while debug waits, after which debug wins.

Ports:
- `clk` in 1: system clock; all state changes on rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `cpu_req` in 1: CPU access request; held until `cpu_ready`.
- `cpu_we` in 1: CPU write (1) / read (0).
- `cpu_addr` in 32: CPU byte address; word index is `cpu_addr[AW+1:2]`.
- `cpu_wdata` in 32: CPU write data.
- `cpu_rdata` out 32: registered CPU read data.
- `cpu_ready` out 1: one-cycle completion pulse to the CPU.
- `dbg_req` in 1: debug access request; held until `dbg_ready`.
- `dbg_we` in 1: debug write (1) / read (0).
- `dbg_addr` in AW: debug word address.
- `dbg_wdata` in 32: debug write data.
- `dbg_rdata` out 32: registered debug read data.
- `dbg_ready` out 1: one-cycle completion pulse to debug.
- `mem_addr` out AW: word address to memory.
- `mem_we` out 1: memory write strobe; memory writes on the clk edge ending the cycle.
- `mem_wdata` out 32: memory write data.
- `mem_rdata` in 32: memory read data, combinational from `mem_addr`.
- `grant` out 2: current owner: 00 none, 01 CPU, 10 debug.
- `align_err` out 1: one-cycle pulse in RESP for a CPU access with `cpu_addr[1:0]` != 0.

## Operation

- FSM states: IDLE, ACC, RESP. The reset state is IDLE.
- IDLE: arbitrate on the rising edge.
  - CPU wins if `cpu_req`=1, unless the starvation counter equals `STARVE_LIMIT` and `dbg_req`=1.
  - Otherwise debug wins if `dbg_req`=1.
  - With no request, the FSM stays in IDLE.
- On a grant, latch owner, we, word address and wdata into request registers, then go to ACC.
- ACC:
  - `mem_addr`, `mem_wdata` and `grant` come from the latched registers.
  - `mem_we` equals the latched we.
  - For a read, `mem_rdata` is loaded into the owner's rdata register at the edge ending ACC.
  - The FSM then goes to RESP.
- RESP:
  - The owner's ready=1 for exactly this cycle.
  - `align_err` is 1 if the access was a misaligned CPU access. The access is still performed using the truncated word address.
  - The FSM then goes to IDLE.
- Outside ACC, `mem_we`=0 and `mem_addr`/`mem_wdata` hold the last latched value.
- `grant` is 00 in IDLE and shows the owner in ACC and RESP.
- rdata registers:
  - Each holds its value until the next read by the same port.
  - Writes never change either rdata register.
  - A debug read never changes `cpu_rdata`, and a CPU read never changes `dbg_rdata`.
- Starvation counter (3 bits, saturating at `STARVE_LIMIT`):
  - Increments on each CPU grant made while `dbg_req`=1.
  - Clears on a debug grant, and on any IDLE edge where `dbg_req`=0.
- Request inputs are sampled only in IDLE. Changes to requests during ACC/RESP have no effect on the access in flight.
- Requesters drop req in the cycle after ready. A req still high at the IDLE edge is treated as a new request.
- `reset` low at any time:
  - The FSM goes immediately to IDLE.
  - All outputs, request registers, rdata registers and the counter go to 0, so `mem_we` drops combinationally.
  - An in-flight access is aborted with no ready pulse.

## Timing

- Reset values: `cpu_rdata`=0, `dbg_rdata`=0, `cpu_ready`=0, `dbg_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `grant`=00, `align_err`=0.
- Latency: req sampled at edge E0 (IDLE→ACC) → ACC during E0..E1 → ready high during E1..E2.
- Throughput: one access per 3 cycles for back-to-back requests.
- Worst-case debug wait: `STARVE_LIMIT` CPU accesses × 3 cycles, plus the in-flight access.
- Simultaneous `cpu_req` and `dbg_req` in IDLE with counter below the limit → CPU granted.

## Test plan

- **Reset:** hold `reset`=0 for 2 cycles with both reqs high → all outputs 0, `grant`=00; release → CPU granted at the first edge.
- **CPU write then read:**
  - CPU write `cpu_addr`=84, `cpu_wdata`=7 → `mem_we`=1 for one cycle with `mem_addr`=21; `cpu_ready` pulses 2 edges after the request.
  - Read-back of 84 → `cpu_rdata`=7.
- **Debug readback:** debug read `dbg_addr`=21 after the CPU write → `dbg_rdata`=7; `cpu_rdata` unchanged.
- **Starvation:** `cpu_req` held high continuously, `dbg_req` high → 4 CPU grants, then a debug grant on the 5th arbitration; counter returns to 0.
- **Misaligned access:** CPU read at `cpu_addr`=0x52 → `align_err` pulses with `cpu_ready`; `mem_addr`=20.
- **Reset mid-write:** drive `reset`=0 during ACC of a write → `mem_we` falls immediately, no ready pulse, FSM in IDLE after release.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundle of the CPU, debug and memory-side signals around
// mem_arbiter.
//   slave  : the arbiter's view. Requests and mem_rdata are inputs; ready,
//            rdata, memory strobes, grant and align_err are outputs.
//   master : the requester/memory view, with every direction reversed.
// AW is the memory word-address width. It must match the arbiter's AW.
interface mem_arbiter_if #(
    parameter int AW = 8
);
    logic          cpu_req;
    logic          cpu_we;
    logic [31:0]   cpu_addr;
    logic [31:0]   cpu_wdata;
    logic [31:0]   cpu_rdata;
    logic          cpu_ready;

    logic          dbg_req;
    logic          dbg_we;
    logic [AW-1:0] dbg_addr;
    logic [31:0]   dbg_wdata;
    logic [31:0]   dbg_rdata;
    logic          dbg_ready;

    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    logic [1:0]    grant;
    logic          align_err;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  mem_rdata,
        output cpu_rdata, cpu_ready, dbg_rdata, dbg_ready,
        output mem_addr, mem_we, mem_wdata, grant, align_err
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output mem_rdata,
        input  cpu_rdata, cpu_ready, dbg_rdata, dbg_ready,
        input  mem_addr, mem_we, mem_wdata, grant, align_err
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one unified instruction/data memory between the CPU
// and a debug/monitor port.
//
// The arbiter serves one access at a time and takes 3 cycles per access.
// The CPU has fixed priority. A starvation counter forces a debug grant
// after STARVE_LIMIT consecutive CPU grants made while debug was waiting.
//
// Ports:
//   clk   : system clock; all state changes on its rising edge.
//   reset : asynchronous, active-low reset.
//   bus   : mem_arbiter_if.slave, which carries the following signals.
//           - CPU request/response: byte address; the word index is
//             cpu_addr[AW+1:2].
//           - Debug request/response: word address.
//           - Memory port: mem_rdata is combinational from mem_addr;
//             memory writes on the edge that ends a cycle with mem_we high.
//           - grant (00 none, 01 CPU, 10 debug).
//           - align_err: pulse that flags a misaligned CPU access.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no owner; arbitrate requests on the next rising edge
// ACC   | latched request driven to memory; read data captured at exit
// RESP  | one-cycle ready (and align_err) pulse to the owner
module mem_arbiter #(
    parameter int AW           = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [1:0] OWN_CPU = 2'b01;
    localparam logic [1:0] OWN_DBG = 2'b10;
    localparam logic [2:0] LIMIT   = 3'(STARVE_LIMIT);

    state_t        state, state_nxt;
    logic          cpu_win, dbg_win;

    logic [1:0]    owner_q;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [31:0]   wdata_q;
    logic          misalign_q;
    logic [31:0]   cpu_rdata_q;
    logic [31:0]   dbg_rdata_q;
    logic [2:0]    starve_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cpu_win       = 1'b0;
        dbg_win       = 1'b0;
        bus.mem_we    = 1'b0;
        bus.grant     = 2'b00;
        bus.cpu_ready = 1'b0;
        bus.dbg_ready = 1'b0;
        bus.align_err = 1'b0;
        case (state)
            IDLE: begin
                // Debug overrides CPU priority only once the CPU has
                // won LIMIT times in a row while debug was waiting.
                if (bus.cpu_req && !(starve_q == LIMIT && bus.dbg_req)) begin
                    cpu_win = 1'b1;
                end else if (bus.dbg_req) begin
                    dbg_win = 1'b1;
                end
                if (cpu_win || dbg_win) begin
                    state_nxt = ACC;
                end
            end
            ACC: begin
                bus.mem_we = we_q;
                bus.grant  = owner_q;
                state_nxt  = RESP;
            end
            RESP: begin
                bus.grant     = owner_q;
                bus.cpu_ready = (owner_q == OWN_CPU);
                bus.dbg_ready = (owner_q == OWN_DBG);
                bus.align_err = misalign_q;
                state_nxt     = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_q     <= 2'b00;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            misalign_q  <= 1'b0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
            starve_q    <= '0;
        end else begin
            if (cpu_win) begin
                owner_q    <= OWN_CPU;
                we_q       <= bus.cpu_we;
                addr_q     <= bus.cpu_addr[AW+1:2];
                wdata_q    <= bus.cpu_wdata;
                misalign_q <= (bus.cpu_addr[1:0] != 2'b00);
            end else if (dbg_win) begin
                owner_q    <= OWN_DBG;
                we_q       <= bus.dbg_we;
                addr_q     <= bus.dbg_addr;
                wdata_q    <= bus.dbg_wdata;
                misalign_q <= 1'b0;
            end

            if (state == ACC && !we_q) begin
                if (owner_q == OWN_CPU) begin
                    cpu_rdata_q <= bus.mem_rdata;
                end else begin
                    dbg_rdata_q <= bus.mem_rdata;
                end
            end

            // The count only moves at IDLE edges. It saturates at LIMIT;
            // at LIMIT a waiting debug request always wins, which clears it.
            if (state == IDLE) begin
                if (dbg_win || !bus.dbg_req) begin
                    starve_q <= '0;
                end else if (cpu_win && starve_q != LIMIT) begin
                    starve_q <= starve_q + 3'd1;
                end
            end
        end
    end

    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.dbg_rdata = dbg_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
    localparam int AW = 8;

    logic clk = 1'b0;
    logic reset;

    mem_arbiter_if #(.AW(AW)) bus ();

    mem_arbiter #(.AW(AW), .STARVE_LIMIT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Memory array: combinational read, write on the clock edge.
    logic [31:0] mem [256];
    assign bus.mem_rdata = mem[bus.mem_addr];

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + 32'(i);
        forever begin
            @(posedge clk);
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        end
    end

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: shadow memory plus the expected rdata registers.
    logic [31:0] model_mem [256];
    logic [31:0] exp_cpu_rd;
    logic [31:0] exp_dbg_rd;

    typedef struct {
        bit          is_dbg;
        bit          we;
        logic [7:0]  word;
        logic [31:0] rdata;
        bit          aerr;
    } exp_t;
    exp_t sb [$];

    task automatic expect_access(input bit is_dbg, input bit we,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        exp_t e;
        e.is_dbg = is_dbg;
        e.we     = we;
        e.word   = is_dbg ? addr[7:0] : addr[9:2];
        e.aerr   = !is_dbg && (addr[1:0] != 2'b00);
        if (we) begin
            model_mem[e.word] = wdata;
        end else if (is_dbg) begin
            exp_dbg_rd = model_mem[e.word];
        end else begin
            exp_cpu_rd = model_mem[e.word];
        end
        e.rdata = is_dbg ? exp_dbg_rd : exp_cpu_rd;
        sb.push_back(e);
    endtask

    // Drives one request, waits (bounded) for its ready and returns what it saw.
    task automatic run_access(input bit is_dbg, input bit we,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              output int lat, output logic acc_we,
                              output logic [7:0] acc_addr, output logic [1:0] acc_grant,
                              output logic [31:0] rd, output logic aerr,
                              output logic rdy_after);
        @(negedge clk);
        if (is_dbg) begin
            bus.dbg_req = 1'b1; bus.dbg_we = we; bus.dbg_addr = addr[7:0]; bus.dbg_wdata = wdata;
        end else begin
            bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wdata;
        end
        lat = -1; acc_we = 1'b0; acc_addr = '0; acc_grant = '0; rd = '0; aerr = 1'b0;
        for (int n = 1; n <= 10 && lat < 0; n++) begin
            @(negedge clk);
            if (n == 1) begin
                acc_we = bus.mem_we; acc_addr = bus.mem_addr; acc_grant = bus.grant;
            end
            if (is_dbg ? bus.dbg_ready : bus.cpu_ready) begin
                lat  = n;
                rd   = is_dbg ? bus.dbg_rdata : bus.cpu_rdata;
                aerr = bus.align_err;
            end
        end
        bus.cpu_req = 1'b0;
        bus.dbg_req = 1'b0;
        @(negedge clk);
        rdy_after = bus.cpu_ready | bus.dbg_ready;
    endtask

    task automatic test_reset;
        exp_t e;
        bit   got;
        reset = 1'b0;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'd0; bus.cpu_wdata = 32'd0;
        bus.dbg_req = 1'b1; bus.dbg_we = 1'b0; bus.dbg_addr = 8'd0;  bus.dbg_wdata = 32'd0;
        repeat (2) @(negedge clk);
        vectors++;
        if (bus.grant !== 2'b00) begin
            miscompares++; $display("FAIL reset_grant: got %b want 00", bus.grant);
        end
        vectors++;
        if ({bus.cpu_rdata, bus.dbg_rdata, bus.cpu_ready, bus.dbg_ready, bus.mem_we,
             bus.mem_addr, bus.mem_wdata, bus.align_err} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: cpu_rd=%h dbg_rd=%h rdy=%b%b we=%b addr=%h wd=%h ae=%b want all 0",
                     bus.cpu_rdata, bus.dbg_rdata, bus.cpu_ready, bus.dbg_ready, bus.mem_we,
                     bus.mem_addr, bus.mem_wdata, bus.align_err);
        end
        expect_access(1'b0, 1'b0, 32'd0, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus.grant !== 2'b01) begin
            miscompares++; $display("FAIL reset_first_grant: got %b want 01", bus.grant);
        end
        got = 1'b0;
        for (int n = 0; n < 5 && !got; n++) begin
            @(negedge clk);
            if (bus.cpu_ready) got = 1'b1;
        end
        bus.cpu_req = 1'b0;
        bus.dbg_req = 1'b0;
        e = sb.pop_front();
        vectors++;
        if (!got || bus.cpu_rdata !== e.rdata) begin
            miscompares++;
            $display("FAIL reset_first_read: ready=%b rdata=%h want ready=1 rdata=%h", got, bus.cpu_rdata, e.rdata);
        end
        repeat (2) @(negedge clk);
        vectors++;
        if (bus.grant !== 2'b00) begin
            miscompares++; $display("FAIL reset_idle_after: grant=%b want 00", bus.grant);
        end
    endtask

    task automatic test_cpu_write_read;
        exp_t e; int lat; logic awe, aerr, rdy2; logic [7:0] aad; logic [1:0] agr; logic [31:0] rd;
        expect_access(1'b0, 1'b1, 32'd84, 32'd7);
        run_access(1'b0, 1'b1, 32'd84, 32'd7, lat, awe, aad, agr, rd, aerr, rdy2);
        e = sb.pop_front();
        vectors++;
        if (lat !== 2) begin miscompares++; $display("FAIL cpu_wr_latency: got %0d want 2", lat); end
        vectors++;
        if ({awe, aad, agr} !== {1'b1, e.word, 2'b01}) begin
            miscompares++; $display("FAIL cpu_wr_acc: we=%b addr=%0d grant=%b want we=1 addr=%0d grant=01", awe, aad, agr, e.word);
        end
        vectors++;
        if (rd !== e.rdata || rdy2 !== 1'b0) begin
            miscompares++; $display("FAIL cpu_wr_rdata: rdata=%h ready_after=%b want rdata=%h ready_after=0", rd, rdy2, e.rdata);
        end
        expect_access(1'b0, 1'b0, 32'd84, 32'd0);
        run_access(1'b0, 1'b0, 32'd84, 32'd0, lat, awe, aad, agr, rd, aerr, rdy2);
        e = sb.pop_front();
        vectors++;
        if (rd !== e.rdata || awe !== 1'b0 || aerr !== 1'b0) begin
            miscompares++; $display("FAIL cpu_readback: rdata=%h we=%b ae=%b want rdata=%h we=0 ae=0", rd, awe, aerr, e.rdata);
        end
    endtask

    task automatic test_dbg_readback;
        exp_t e; int lat; logic awe, aerr, rdy2; logic [7:0] aad; logic [1:0] agr; logic [31:0] rd;
        expect_access(1'b1, 1'b0, 32'd21, 32'd0);
        run_access(1'b1, 1'b0, 32'd21, 32'd0, lat, awe, aad, agr, rd, aerr, rdy2);
        e = sb.pop_front();
        vectors++;
        if (rd !== e.rdata || agr !== 2'b10 || lat !== 2) begin
            miscompares++; $display("FAIL dbg_read: rdata=%h grant=%b lat=%0d want rdata=%h grant=10 lat=2", rd, agr, lat, e.rdata);
        end
        vectors++;
        if (bus.cpu_rdata !== exp_cpu_rd) begin
            miscompares++; $display("FAIL dbg_read_cpu_rd: got %h want %h", bus.cpu_rdata, exp_cpu_rd);
        end
        expect_access(1'b1, 1'b1, 32'd50, 32'hCAFE_0001);
        run_access(1'b1, 1'b1, 32'd50, 32'hCAFE_0001, lat, awe, aad, agr, rd, aerr, rdy2);
        e = sb.pop_front();
        vectors++;
        if ({awe, aad} !== {1'b1, e.word} || rd !== e.rdata || bus.cpu_rdata !== exp_cpu_rd) begin
            miscompares++;
            $display("FAIL dbg_write: we=%b addr=%0d dbg_rd=%h cpu_rd=%h want we=1 addr=%0d dbg_rd=%h cpu_rd=%h",
                     awe, aad, rd, bus.cpu_rdata, e.word, e.rdata, exp_cpu_rd);
        end
        expect_access(1'b0, 1'b0, 32'd200, 32'd0);
        run_access(1'b0, 1'b0, 32'd200, 32'd0, lat, awe, aad, agr, rd, aerr, rdy2);
        e = sb.pop_front();
        vectors++;
        if (rd !== e.rdata || bus.dbg_rdata !== exp_dbg_rd) begin
            miscompares++; $display("FAIL cpu_read_dbg_data: cpu_rd=%h dbg_rd=%h want cpu_rd=%h dbg_rd=%h", rd, bus.dbg_rdata, e.rdata, exp_dbg_rd);
        end
    endtask

    task automatic test_misaligned;
        exp_t e; int lat; logic awe, aerr, rdy2; logic [7:0] aad; logic [1:0] agr; logic [31:0] rd;
        expect_access(1'b0, 1'b0, 32'h52, 32'd0);
        run_access(1'b0, 1'b0, 32'h52, 32'd0, lat, awe, aad, agr, rd, aerr, rdy2);
        e = sb.pop_front();
        vectors++;
        if (aerr !== e.aerr || aad !== e.word || rd !== e.rdata) begin
            miscompares++; $display("FAIL misaligned: ae=%b addr=%0d rdata=%h want ae=%b addr=%0d rdata=%h", aerr, aad, rd, e.aerr, e.word, e.rdata);
        end
        vectors++;
        if (bus.align_err !== 1'b0 || rdy2 !== 1'b0) begin
            miscompares++; $display("FAIL misaligned_pulse_width: ae=%b ready=%b want 0 0", bus.align_err, rdy2);
        end
    endtask

    task automatic test_starvation;
        exp_t e; int ngr; logic [1:0] prev_gr, want_gr;
        for (int i = 0; i < 6; i++) begin
            if (i == 4) expect_access(1'b1, 1'b0, 32'd31, 32'd0);
            else        expect_access(1'b0, 1'b0, 32'd120, 32'd0);
        end
        @(negedge clk);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'd120;
        bus.dbg_req = 1'b1; bus.dbg_we = 1'b0; bus.dbg_addr = 8'd31;
        ngr = 0;
        prev_gr = 2'b00;
        for (int n = 0; n < 40 && ngr < 6; n++) begin
            @(negedge clk);
            if (bus.grant !== 2'b00 && prev_gr === 2'b00) begin
                e = sb.pop_front();
                want_gr = e.is_dbg ? 2'b10 : 2'b01;
                vectors++;
                if (bus.grant !== want_gr || bus.mem_addr !== e.word) begin
                    miscompares++;
                    $display("FAIL starve_grant%0d: grant=%b addr=%0d want grant=%b addr=%0d", ngr, bus.grant, bus.mem_addr, want_gr, e.word);
                end
                ngr++;
                if (ngr == 6) begin
                    bus.cpu_req = 1'b0;
                    bus.dbg_req = 1'b0;
                end
            end
            prev_gr = bus.grant;
        end
        bus.cpu_req = 1'b0;
        bus.dbg_req = 1'b0;
        vectors++;
        if (ngr != 6) begin
            miscompares++; $display("FAIL starve_timeout: grants=%0d want 6", ngr);
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (bus.cpu_rdata !== exp_cpu_rd || bus.dbg_rdata !== exp_dbg_rd) begin
            miscompares++; $display("FAIL starve_rdata: cpu=%h dbg=%h want cpu=%h dbg=%h", bus.cpu_rdata, bus.dbg_rdata, exp_cpu_rd, exp_dbg_rd);
        end
        sb.delete();
    endtask

    task automatic test_reset_mid_write;
        exp_t e; int lat; logic awe, aerr, rdy2; logic [7:0] aad; logic [1:0] agr; logic [31:0] rd;
        bit saw_ready;
        @(negedge clk);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 32'd64; bus.cpu_wdata = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        vectors++;
        if (bus.mem_we !== 1'b1) begin
            miscompares++; $display("FAIL midwr_acc_we: got %b want 1", bus.mem_we);
        end
        #1 reset = 1'b0;
        #1;
        vectors++;
        if (bus.mem_we !== 1'b0 || bus.grant !== 2'b00) begin
            miscompares++; $display("FAIL midwr_abort: we=%b grant=%b want 0 00", bus.mem_we, bus.grant);
        end
        bus.cpu_req = 1'b0;
        bus.cpu_we  = 1'b0;
        saw_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus.cpu_ready || bus.dbg_ready) saw_ready = 1'b1;
        end
        exp_cpu_rd = 32'd0;
        exp_dbg_rd = 32'd0;
        vectors++;
        if (saw_ready || bus.cpu_rdata !== exp_cpu_rd || bus.dbg_rdata !== exp_dbg_rd) begin
            miscompares++; $display("FAIL midwr_reset_state: ready=%b cpu_rd=%h dbg_rd=%h want 0 0 0", saw_ready, bus.cpu_rdata, bus.dbg_rdata);
        end
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus.grant !== 2'b00 || bus.cpu_ready !== 1'b0) begin
            miscompares++; $display("FAIL midwr_idle: grant=%b ready=%b want 00 0", bus.grant, bus.cpu_ready);
        end
        expect_access(1'b1, 1'b0, 32'd16, 32'd0);
        run_access(1'b1, 1'b0, 32'd16, 32'd0, lat, awe, aad, agr, rd, aerr, rdy2);
        e = sb.pop_front();
        vectors++;
        if (rd !== e.rdata || lat !== 2) begin
            miscompares++; $display("FAIL midwr_no_write: rdata=%h lat=%0d want rdata=%h lat=2", rd, lat, e.rdata);
        end
    endtask

    initial begin
        reset = 1'b0;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.dbg_req = 1'b0; bus.dbg_we = 1'b0; bus.dbg_addr = '0; bus.dbg_wdata = '0;
        for (int i = 0; i < 256; i++) model_mem[i] = 32'h1000_0000 + 32'(i);
        exp_cpu_rd = 32'd0;
        exp_dbg_rd = 32'd0;
        test_reset();
        test_cpu_write_read();
        test_dbg_readback();
        test_misaligned();
        test_starvation();
        test_reset_mid_write();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
